// File: rtl/uart_rx_frontend_if.sv
// -----------------------------------------------------------------------------
// uart_rx_frontend_if
// Write-side link between the UART receiver and the downstream receive FIFO.
//
// Signals:
//   dout        receiver -> FIFO din     received byte
//   dout_valid  receiver -> FIFO wr_en   one-cycle write strobe
//   fifo_full   FIFO -> receiver         FIFO cannot accept a write
//
// Modports:
//   master  used by the receiver (drives dout/dout_valid, reads fifo_full)
//   slave   used by the FIFO side (reads dout/dout_valid, drives fifo_full)
//
// DATA_WIDTH must match the DATA_WIDTH of the attached uart_rx_frontend.
// -----------------------------------------------------------------------------
interface uart_rx_frontend_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  fifo_full;

  modport master (
    output dout,
    output dout_valid,
    input  fifo_full
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output fifo_full
  );

endinterface

// File: rtl/uart_rx_frontend.sv
// -----------------------------------------------------------------------------
// uart_rx_frontend
// UART receiver: deserialises the asynchronous rx line (LSB first, one stop
// bit) and writes each good byte into the downstream receive FIFO. Framing
// and overrun problems are reported as one-cycle status pulses.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   rx           raw serial input, asynchronous to clk, idles high
//   fifo         FIFO write side (master modport): dout, dout_valid, fifo_full
//   frame_err    one-cycle pulse, stop bit sampled low
//   overrun_err  one-cycle pulse, byte written while the FIFO was full
//   parity_err   one-cycle pulse, even-parity mismatch (parity build only)
//   busy         high whenever the receiver is not idle
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit, and the parity_err output.
//
// CLKS_PER_BIT = CLK_FREQ/BAUD (truncated) must be at least 4 so that the
// mid-start-bit sample point is well defined.
// -----------------------------------------------------------------------------
module uart_rx_frontend #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  uart_rx_frontend_if.master fifo,
  output logic               frame_err,
  output logic               overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic               parity_err,
`endif
  output logic               busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

`ifdef UART_RX_PARITY_EN
  // Even parity holds when data bits plus parity bit XOR to zero.
  function automatic logic even_parity_ok(input logic [DATA_WIDTH-1:0] data,
                                          input logic                  par);
    return ~(^{data, par});
  endfunction
`endif

  // Synchroniser stages (1,2) plus the edge-detect stage (3); reset to the
  // idle line level so reset release never looks like a start edge.
  logic                  sync1_q, sync2_q, sync3_q;
  logic                  rx_cur, rx_prev;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_err_q, overrun_err_d;
  logic                  busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit_q, par_bit_d;
  logic                  parity_err_q, parity_err_d;
`endif

  assign rx_cur  = sync2_q;
  assign rx_prev = sync3_q;

  // Synchronise rx into the clk domain and keep one extra stage for edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Next-state and output-pulse logic for the receive FSM.
  always_comb begin
    state_d       = state_q;
    baud_d        = baud_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    dout_d        = dout_q;
    dout_valid_d  = 1'b0;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d     = par_bit_q;
    parity_err_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // Only a genuine high-to-low transition arms the receiver, so a
        // line stuck low (break) cannot start a stream of frames.
        if (rx_prev && !rx_cur) begin
          baud_d  = '0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (baud_q == BAUD_HALF) begin
          if (rx_cur) begin
            // Line already back high at mid start bit: treat as a glitch.
            state_d = ST_IDLE;
          end else begin
            baud_d  = '0;
            bit_d   = '0;
            state_d = ST_DATA;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d         = '0;
          shift_d[bit_q] = rx_cur;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (baud_q == BAUD_LAST) begin
          baud_d    = '0;
          par_bit_d = rx_cur;
          state_d   = ST_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_IDLE;
          if (rx_cur) begin
`ifdef UART_RX_PARITY_EN
            if (even_parity_ok(shift_q, par_bit_q)) begin
              dout_d        = shift_q;
              dout_valid_d  = 1'b1;
              overrun_err_d = fifo.fifo_full;
            end else begin
              parity_err_d = 1'b1;
            end
`else
            dout_d        = shift_q;
            dout_valid_d  = 1'b1;
            overrun_err_d = fifo.fifo_full;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // busy is registered from the next state so it tracks state_q exactly.
    busy_d = (state_d != ST_IDLE);
  end

  // FSM, datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      baud_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      busy_q        <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q     <= par_bit_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign fifo.dout       = dout_q;
  assign fifo.dout_valid = dout_valid_q;
  assign frame_err       = frame_err_q;
  assign overrun_err     = overrun_err_q;
  assign busy            = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err      = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frontend
// Directed bench for uart_rx_frontend at 16 clocks per bit. The bench keeps a
// frame-level model: every frame it sends queues the event it must cause
// (byte written, framing error or parity error), the cycle it must appear
// and whether it overruns. A negedge process compares DUT pulses and dout
// against that model every cycle; literal checks pin the model's values.
// -----------------------------------------------------------------------------
module tb_uart_rx_frontend;

  localparam int CPB     = 16;
  localparam int LAT     = 156;
  localparam int LAT_TOL = 2;
  localparam int K_VALID = 0;
  localparam int K_FRAME = 1;
  localparam int K_PERR  = 2;
  localparam int K_BAD   = 3;

  typedef struct {
    int         t;
    int         kind;
    logic [7:0] data;
    logic       ovr;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic frame_err;
  logic overrun_err;
  logic busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`else
  wire  parity_err = 1'b0;
`endif

  uart_rx_frontend_if #(.DATA_WIDTH(8)) fif ();

  uart_rx_frontend #(
    .CLK_FREQ  (1600000),
    .BAUD      (100000),
    .DATA_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .fifo       (fif),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  ev_t        exp_q[$];
  int         valid_t[$];
  logic [7:0] model_dout = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive point: 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Serialise one frame and queue the event it must produce.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    ev_t  e;
    logic p;
    p      = (^d) ^ par_flip;
    e.t    = cyc + LAT;
    e.data = d;
`ifdef UART_RX_PARITY_EN
    e.t    = e.t + CPB;
    e.kind = !stop_b ? K_FRAME : (par_flip ? K_PERR : K_VALID);
`else
    e.kind = !stop_b ? K_FRAME : K_VALID;
`endif
    e.ovr  = fif.fifo_full && (e.kind == K_VALID);
    exp_q.push_back(e);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = p;
    tick(CPB);
`else
    if (p === 1'bx) rx = 1'b1;
`endif
    rx = stop_b;
    tick(CPB);
  endtask

  // Per-cycle comparison of DUT outputs against the frame-level model.
  always @(negedge clk) begin
    int  got;
    ev_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      model_dout = 8'h00;
    end else begin
      if (fif.dout_valid || frame_err || overrun_err || parity_err) begin
        chk("pulse_exclusive", {31'd0, fif.dout_valid & frame_err}, 32'd0);
        got = fif.dout_valid ? K_VALID : frame_err ? K_FRAME : parity_err ? K_PERR : K_BAD;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", got, K_BAD);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", got, e.kind);
          chk("event_time_ok", {31'd0, (cyc >= e.t - LAT_TOL) && (cyc <= e.t + LAT_TOL)}, 32'd1);
          chk("overrun_err", {31'd0, overrun_err}, {31'd0, e.ovr});
          if (e.kind == K_VALID) begin
            model_dout = e.data;
            valid_t.push_back(cyc);
          end
        end
      end
      if (exp_q.size() != 0 && cyc > exp_q[0].t + LAT_TOL) begin
        chk("missing_event_kind", K_BAD, exp_q[0].kind);
        void'(exp_q.pop_front());
      end
      chk("dout", {24'd0, fif.dout}, {24'd0, model_dout});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rx            = 1'b1;
    rst           = 1'b1;
    fif.fifo_full = 1'b0;
    tick(3);
    chk("reset_dout", {24'd0, fif.dout}, 32'd0);
    chk("reset_valid", {31'd0, fif.dout_valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_overrun", {31'd0, overrun_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick(5);

    // 1. single frame
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(4);
    chk("t1_busy_low", {31'd0, busy}, 32'd0);
    chk("t1_dout", {24'd0, fif.dout}, 32'h0000_00A5);

    // 2. back-to-back frames, no idle gap
    valid_t.delete();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(4);
    chk("t2_valid_count", valid_t.size(), 32'd3);
    if (valid_t.size() == 3) begin
      chk("t2_gap01", {31'd0, (valid_t[1] - valid_t[0] >= 158) && (valid_t[1] - valid_t[0] <= 162)}, 32'd1);
      chk("t2_gap12", {31'd0, (valid_t[2] - valid_t[1] >= 158) && (valid_t[2] - valid_t[1] <= 162)}, 32'd1);
    end else begin
      chk("t2_gaps_present", valid_t.size(), 32'd3);
    end
    chk("t2_dout", {24'd0, fif.dout}, 32'h0000_003C);

    // 3. glitch rejection
    rx = 1'b0;
    tick(4);
    chk("t3_busy_high", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    tick(30);
    chk("t3_busy_low", {31'd0, busy}, 32'd0);
    chk("t3_dout", {24'd0, fif.dout}, 32'h0000_003C);

    // 4. framing error followed by a break, then a normal frame
    send_frame(8'h55, 1'b0, 1'b0);
    rx = 1'b0;
    tick(400);
    chk("t4_dout_kept", {24'd0, fif.dout}, 32'h0000_003C);
    chk("t4_busy_low", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    tick(32);
    send_frame(8'h12, 1'b1, 1'b0);
    tick(4);
    chk("t4_dout", {24'd0, fif.dout}, 32'h0000_0012);

    // 5. overrun
    fif.fifo_full = 1'b1;
    send_frame(8'h7E, 1'b1, 1'b0);
    tick(4);
    fif.fifo_full = 1'b0;
    chk("t5_dout", {24'd0, fif.dout}, 32'h0000_007E);

    // 6. reset after the third data bit of 0xC3
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 2) ? 1'b0 : 1'b1;
      tick(CPB);
    end
    rst = 1'b1;
    #1;
    chk("t6_rst_dout", {24'd0, fif.dout}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_valid", {31'd0, fif.dout_valid}, 32'd0);
    rx = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(20);
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(4);
    chk("t6_dout", {24'd0, fif.dout}, 32'h0000_00C3);

`ifdef UART_RX_PARITY_EN
    // parity mismatch: 0x03 has even data parity, so parity bit 1 is wrong
    send_frame(8'h03, 1'b1, 1'b1);
    tick(4);
    chk("par_dout_kept", {24'd0, fif.dout}, 32'h0000_00C3);
`endif

    tick(20);
    chk("all_events_seen", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
